pc_seq: RTL and testbench

- Parametrised successor program-counter sequencer for the instruction fetch path.
- Supports:
  - sequential increment
  - fixed-distance skip branch
  - signed relative branch
  - paged absolute jump
  - subroutine call/return through an internal return-address stack (RAS)
  - fetch stall
- Drives the instruction ROM address directly. Control strobes come from the decoder.

---
 rtl/pc_seq.sv | 150 +++++++++++++++
 tb/tb_pc_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// pc_seq: successor program-counter sequencer with an internal return-address stack.
// Defining PC_SEQ_HALT_EN adds the halt input and the sticky halted output.
module pc_seq #(
   parameter int             D         = 12,
   parameter int             T         = 8,
   parameter int             SKIP      = 2,
   parameter int             RAS_DEPTH = 4,
   parameter logic [D-1:0]   RESET_VEC = {D{1'b0}}
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         skip_en,
   input  logic         rel_en,
   input  logic         jump_en,
   input  logic         call_en,
   input  logic         ret_en,
   input  logic [T-1:0] target,
`ifdef PC_SEQ_HALT_EN
   input  logic         halt,
   output logic         halted,
`endif
   output logic [D-1:0] prog_ctr,
   output logic         ras_empty,
   output logic         ras_full,
   output logic         ras_err
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [D-1:0]  ONE_C      = D'(1);
   localparam logic [D-1:0]  SKIP_C     = D'(SKIP);
   localparam logic [CW-1:0] CNT_ONE_C  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};
   localparam logic [CW-1:0] DEPTH_C    = CW'(RAS_DEPTH);

   function automatic logic [D-1:0] sign_ext(input logic [T-1:0] v);
      return {{(D-T){v[T-1]}}, v};
   endfunction

   logic [D-1:0]  pc_r;
   logic [D-1:0]  pc_nxt_s;
   logic [D-1:0]  pc_inc_s;
   logic [D-1:0]  page_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          err_r;
   logic          err_nxt_s;
   logic          push_s;
   logic          empty_s;
   logic          full_s;
   logic [PW-1:0] top_idx_s;
   logic [PW-1:0] push_idx_s;
   logic [D-1:0]  ras_mem_r [RAS_DEPTH];
`ifdef PC_SEQ_HALT_EN
   logic          halted_r;
   logic          halted_nxt_s;
`endif

   assign pc_inc_s   = pc_r + ONE_C;
   assign page_s     = {pc_r[D-1:T], target};
   assign empty_s    = (cnt_r == CNT_ZERO_C);
   assign full_s     = (cnt_r == DEPTH_C);
   assign top_idx_s  = PW'(cnt_r - CNT_ONE_C);
   assign push_idx_s = PW'(cnt_r);

   // Next-state selection in strobe priority order; only the winner acts.
   always_comb begin
      pc_nxt_s  = pc_inc_s;
      cnt_nxt_s = cnt_r;
      err_nxt_s = err_r;
      push_s    = 1'b0;
`ifdef PC_SEQ_HALT_EN
      halted_nxt_s = halted_r;
      if (halted_r) begin
         pc_nxt_s = pc_r;
      end else if (stall) begin
         pc_nxt_s = pc_r;
      end else if (halt) begin
         pc_nxt_s     = pc_r;
         halted_nxt_s = 1'b1;
      end else
`else
      if (stall) begin
         pc_nxt_s = pc_r;
      end else
`endif
      if (ret_en) begin
         if (!empty_s) begin
            pc_nxt_s  = ras_mem_r[top_idx_s];
            cnt_nxt_s = cnt_r - CNT_ONE_C;
         end else begin
            pc_nxt_s  = pc_inc_s;
            err_nxt_s = 1'b1;
         end
      end else if (call_en) begin
         pc_nxt_s = page_s;
         if (!full_s) begin
            push_s    = 1'b1;
            cnt_nxt_s = cnt_r + CNT_ONE_C;
         end else begin
            err_nxt_s = 1'b1;
         end
      end else if (skip_en) begin
         pc_nxt_s = pc_r + SKIP_C;
      end else if (rel_en) begin
         pc_nxt_s = pc_r + sign_ext(target);
      end else if (jump_en) begin
         pc_nxt_s = page_s;
      end else begin
         pc_nxt_s = pc_inc_s;
      end
   end

   // Control state: program counter, stack depth and sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_r     <= RESET_VEC;
         cnt_r    <= CNT_ZERO_C;
         err_r    <= 1'b0;
`ifdef PC_SEQ_HALT_EN
         halted_r <= 1'b0;
`endif
      end else begin
         pc_r     <= pc_nxt_s;
         cnt_r    <= cnt_nxt_s;
         err_r    <= err_nxt_s;
`ifdef PC_SEQ_HALT_EN
         halted_r <= halted_nxt_s;
`endif
      end
   end

   // Stack storage needs no reset: entries above the count are never read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         ras_mem_r[push_idx_s] <= pc_inc_s;
      end
   end

   assign prog_ctr  = pc_r;
   assign ras_empty = empty_s;
   assign ras_full  = full_s;
   assign ras_err   = err_r;
`ifdef PC_SEQ_HALT_EN
   assign halted    = halted_r;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: a queue/arithmetic reference model predicts each cycle,
// a monitor compares the DUT after every rising edge.
module tb_pc_seq;

   localparam int D     = 12;
   localparam int T     = 8;
   localparam int SKIP  = 2;
   localparam int DEPTH = 4;
   localparam int MASK  = (1 << D) - 1;
   localparam int TMASK = (1 << T) - 1;

   logic         clk;
   logic         reset;
   logic         stall, skip_en, rel_en, jump_en, call_en, ret_en;
   logic [T-1:0] target;
   logic [D-1:0] prog_ctr;
   logic         ras_empty, ras_full, ras_err;
`ifdef PC_SEQ_HALT_EN
   logic         halt;
   logic         halted;
`endif

   pc_seq #(.D(D), .T(T), .SKIP(SKIP), .RAS_DEPTH(DEPTH), .RESET_VEC(12'h000)) dut (
      .clk(clk), .reset(reset), .stall(stall), .skip_en(skip_en), .rel_en(rel_en),
      .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en), .target(target),
`ifdef PC_SEQ_HALT_EN
      .halt(halt), .halted(halted),
`endif
      .prog_ctr(prog_ctr), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
   );

   typedef struct {
      int pc;
      bit empty;
      bit full;
      bit err;
   } exp_t;

   exp_t sb_q[$];
   int   m_pc;
   int   m_stack[$];
   bit   m_err;
   int   n_chk;
   int   n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int want);
      n_chk++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic model_reset();
      m_pc  = 0;
      m_stack.delete();
      m_err = 1'b0;
   endtask

   // Drive one cycle of strobes at a falling edge, predict the result, queue it.
   task automatic step(input bit s, input bit r, input bit c, input bit k,
                       input bit l, input bit j, input int tg);
      exp_t e;
      int   off;
      stall = s; ret_en = r; call_en = c; skip_en = k; rel_en = l; jump_en = j;
      target = T'(tg);
      if (s) begin
         m_pc = m_pc;
      end else if (r) begin
         if (m_stack.size() > 0) begin
            m_pc = m_stack.pop_back();
         end else begin
            m_pc  = (m_pc + 1) & MASK;
            m_err = 1'b1;
         end
      end else if (c) begin
         if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) & MASK);
         else m_err = 1'b1;
         m_pc = (m_pc & ~TMASK & MASK) | (tg & TMASK);
      end else if (k) begin
         m_pc = (m_pc + SKIP) & MASK;
      end else if (l) begin
         off = tg & TMASK;
         if (off >= (1 << (T - 1))) off = off - (1 << T);
         m_pc = (m_pc + off) & MASK;
      end else if (j) begin
         m_pc = (m_pc & ~TMASK & MASK) | (tg & TMASK);
      end else begin
         m_pc = (m_pc + 1) & MASK;
      end
      e.pc    = m_pc;
      e.empty = (m_stack.size() == 0);
      e.full  = (m_stack.size() == DEPTH);
      e.err   = m_err;
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   // Monitor: compares the DUT against the oldest prediction after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("prog_ctr", int'(prog_ctr), e.pc);
         chk("ras_empty", int'(ras_empty), int'(e.empty));
         chk("ras_full", int'(ras_full), int'(e.full));
         chk("ras_err", int'(ras_err), int'(e.err));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_fail = 0;
      stall = 1'b0; skip_en = 1'b0; rel_en = 1'b0; jump_en = 1'b0;
      call_en = 1'b0; ret_en = 1'b0; target = '0;
`ifdef PC_SEQ_HALT_EN
      halt = 1'b0;
`endif
      reset = 1'b0;
      model_reset();
      #12;
      chk("reset_pc", int'(prog_ctr), 0);
      chk("reset_empty", int'(ras_empty), 1);
      chk("reset_full", int'(ras_full), 0);
      chk("reset_err", int'(ras_err), 0);
      @(negedge clk);
      reset = 1'b1;

      repeat (3) idle();
      // relative branches around 0x0FE
      step(0, 0, 0, 0, 0, 1, 'hFE);
      step(0, 0, 0, 0, 1, 0, 'hFE);
      step(0, 0, 0, 0, 1, 0, 'h05);
      while (m_pc < 'h300) step(0, 0, 0, 0, 1, 0, 'h7F);
      step(0, 0, 0, 0, 0, 1, 'hA0);
      step(0, 0, 0, 0, 0, 1, 'h12);
      step(0, 0, 0, 0, 0, 1, 'hA0);
      step(0, 0, 0, 1, 0, 1, 'h12);
      // wrap from 0xFFF to 0x000
      while (m_pc < 'hF00) step(0, 0, 0, 0, 1, 0, 'h7F);
      step(0, 0, 0, 0, 0, 1, 'hFF);
      idle();
      // single call / return
      step(0, 0, 0, 0, 0, 1, 'h10);
      step(0, 0, 1, 0, 0, 0, 'h80);
      idle();
      step(0, 1, 0, 0, 0, 0, 0);
      // overflow and underflow of the stack
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 'h20 + 'h10 * i);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0);
      // stall with call pending
      step(0, 0, 1, 0, 0, 0, 'h44);
      step(1, 0, 1, 0, 0, 0, 'h55);
      step(1, 0, 1, 0, 0, 0, 'h66);
      idle();

      // asynchronous reset away from the clock edge
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_pc", int'(prog_ctr), 0);
      chk("async_reset_empty", int'(ras_empty), 1);
      chk("async_reset_err", int'(ras_err), 0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      idle();
      step(0, 0, 1, 0, 0, 0, 'h33);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(7) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0,
              $urandom_range(4) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0,
              int'($urandom_range(255)));
      end
      idle();
      @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
